// File: rtl/int_seq_ctrl.sv
// Interrupt sequencer: edge-detects irq_in into PEND, redirects the CPU to BASE+(sel<<3) and back to EPC on eret.
// Redirect is combinational in the cycle it is granted; MIO_ready=0 freezes all FSM transitions but not request capture.
module int_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  irq_in,
  input  logic [31:0] pc_next,
  input  logic        MIO_ready,
  input  logic        eret,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        int_code,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [1:0]  int_id,
  output logic [31:0] epc
);

  typedef enum logic [1:0] {IDLE, SERVICE, GUARD} state_t;

  state_t      state_q, state_d;
  logic [3:0]  irq_q;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  pend_q, pend_d;
  logic [31:0] base_q, base_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  id_q, id_d;
  logic [3:0]  rise, act, clr;
  logic [1:0]  sel;

  assign rise = irq_in & ~irq_q;
  assign act  = pend_q & mask_q;

  always_comb begin
    casez (act)
      4'b???1: sel = 2'd0;
      4'b??10: sel = 2'd1;
      4'b?100: sel = 2'd2;
      4'b1000: sel = 2'd3;
      default: sel = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    epc_d       = epc_q;
    id_d        = id_q;
    mask_d      = mask_q;
    base_d      = base_q;
    clr         = 4'b0000;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    int_code    = 1'b0;

    case (state_q)
      IDLE: begin
        if ((act != 4'b0000) && MIO_ready) begin
          redirect    = 1'b1;
          redirect_pc = base_q + {27'd0, sel, 3'b000};
          epc_d       = pc_next;
          id_d        = sel;
          clr         = 4'b0001 << sel;
          state_d     = SERVICE;
        end
      end
      SERVICE: begin
        int_code = 1'b1;
        if (eret && MIO_ready) begin
          redirect    = 1'b1;
          redirect_pc = epc_q;
          state_d     = GUARD;
        end
      end
      GUARD: begin
        // Hold off re-entry until one instruction at EPC has retired.
        if (MIO_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cfg_we) begin
      case (cfg_addr)
        2'd0:    mask_d = cfg_wdata[3:0];
        2'd1:    clr    = clr | cfg_wdata[3:0];
        2'd2:    base_d = {cfg_wdata[31:2], 2'b00};
        default: ;
      endcase
    end

    // A fresh edge always beats any clear of the same bit.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      irq_q   <= 4'b0000;
      mask_q  <= 4'b0000;
      pend_q  <= 4'b0000;
      base_q  <= 32'h0000_0004;
      epc_q   <= 32'd0;
      id_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_in;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      base_q  <= base_d;
      epc_q   <= epc_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    case (cfg_addr)
      2'd0:    cfg_rdata = {28'd0, mask_q};
      2'd1:    cfg_rdata = {28'd0, pend_q};
      2'd2:    cfg_rdata = base_q;
      default: cfg_rdata = epc_q;
    endcase
  end

  assign int_id = id_q;
  assign epc    = epc_q;

endmodule

// File: tb/tb_int_seq_ctrl.sv
// Self-checking bench for int_seq_ctrl: expected redirect targets are queued when the request is driven.
module tb_int_seq_ctrl;

  logic        clk, rst;
  logic [3:0]  irq_in;
  logic [31:0] pc_next;
  logic        MIO_ready, eret, cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        int_code, redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  int_id;
  logic [31:0] epc;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  id;
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc;

  int_seq_ctrl dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .pc_next(pc_next), .MIO_ready(MIO_ready),
    .eret(eret), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .int_code(int_code), .redirect(redirect),
    .redirect_pc(redirect_pc), .int_id(int_id), .epc(epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    step();
    eret = 1'b0;
    step();
  endtask

  task automatic wait_redirect(output int c);
    c = -1;
    for (int i = 0; i < 20; i++) begin
      if (redirect === 1'b1) begin
        c = i;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    n_vec++; if (int_code !== 1'b0) begin n_err++; $display("FAIL rst_int_code got %b want 0", int_code); end
    n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL rst_redirect got %b want 0", redirect); end
    n_vec++; if (redirect_pc !== 32'd0) begin n_err++; $display("FAIL rst_redirect_pc got %h want 0", redirect_pc); end
    n_vec++; if (int_id !== 2'd0 || epc !== 32'd0) begin n_err++; $display("FAIL rst_id_epc got %0d/%h want 0/0", int_id, epc); end
    cfg_addr = 2'd2; #1;
    n_vec++; if (cfg_rdata !== 32'h4) begin n_err++; $display("FAIL rst_base got %h want 4", cfg_rdata); end
    // irq held high through reset release counts as an edge
    irq_in = 4'b0001;
    @(posedge clk); #1 rst = 1'b0;
    step();
    cfg_addr = 2'd1; #1;
    n_vec++; if (cfg_rdata !== 32'h1) begin n_err++; $display("FAIL rst_hold_edge pend got %h want 1", cfg_rdata); end
    n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL rst_mask0_redirect got %b want 0", redirect); end
    irq_in = 4'b0000;
    cfg_write(2'd1, 32'h1);
    cfg_addr = 2'd1; #1;
    n_vec++; if (cfg_rdata !== 32'h0) begin n_err++; $display("FAIL w1c_pend got %h want 0", cfg_rdata); end
  endtask

  task automatic test_entry();
    cfg_write(2'd0, 32'hF);
    cfg_write(2'd2, 32'h100);
    pc_next = 32'h40; irq_in = 4'b0100;
    exp_q.push_back('{pc: 32'h110, id: 2'd2, epc: 32'h40});
    #1;
    n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL entry_early redirect got %b want 0", redirect); end
    step();
    wait_redirect(cyc);
    n_vec++; if (cyc !== 0) begin n_err++; $display("FAIL entry_latency got %0d want 0", cyc); end
    if (exp_q.size() == 0) begin n_vec++; n_err++; $display("FAIL entry_sb empty"); end
    else begin
      e = exp_q.pop_front();
      n_vec++; if (redirect_pc !== e.pc) begin n_err++; $display("FAIL entry_pc got %h want %h", redirect_pc, e.pc); end
      step();
      n_vec++; if (int_code !== 1'b1) begin n_err++; $display("FAIL entry_int_code got %b want 1", int_code); end
      n_vec++; if (int_id !== e.id || epc !== e.epc) begin n_err++; $display("FAIL entry_id_epc got %0d/%h want %0d/%h", int_id, epc, e.id, e.epc); end
    end
    cfg_addr = 2'd1; #1;
    n_vec++; if (cfg_rdata[2] !== 1'b0) begin n_err++; $display("FAIL entry_pend2 got %b want 0", cfg_rdata[2]); end
    eret = 1'b1; #1;
    n_vec++; if (redirect !== 1'b1 || redirect_pc !== 32'h40) begin n_err++; $display("FAIL eret_redirect got %b/%h want 1/40", redirect, redirect_pc); end
    step();
    eret = 1'b0; #1;
    n_vec++; if (int_code !== 1'b0 || redirect !== 1'b0) begin n_err++; $display("FAIL guard_outs got %b/%b want 0/0", int_code, redirect); end
    step();
    irq_in = 4'b0000;
    step();
  endtask

  task automatic test_priority();
    pc_next = 32'h200; irq_in = 4'b1010;
    exp_q.push_back('{pc: 32'h108, id: 2'd1, epc: 32'h200});
    exp_q.push_back('{pc: 32'h118, id: 2'd3, epc: 32'h204});
    step();
    for (int k = 0; k < 2; k++) begin
      wait_redirect(cyc);
      n_vec++; if (cyc !== 0) begin n_err++; $display("FAIL prio_latency%0d got %0d want 0", k, cyc); end
      if (exp_q.size() == 0) begin n_vec++; n_err++; $display("FAIL prio_sb empty"); end
      else begin
        e = exp_q.pop_front();
        n_vec++; if (redirect_pc !== e.pc) begin n_err++; $display("FAIL prio_pc%0d got %h want %h", k, redirect_pc, e.pc); end
        step();
        n_vec++; if (int_id !== e.id || epc !== e.epc) begin n_err++; $display("FAIL prio_id%0d got %0d/%h want %0d/%h", k, int_id, epc, e.id, e.epc); end
      end
      pc_next = 32'h204;
      eret = 1'b1;
      step();
      eret = 1'b0; #1;
      n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL prio_guard%0d redirect got %b want 0", k, redirect); end
      step();
    end
    irq_in = 4'b0000;
    step();
  endtask

  task automatic test_eret_stall();
    pc_next = 32'h40; irq_in = 4'b0001;
    exp_q.push_back('{pc: 32'h100, id: 2'd0, epc: 32'h40});
    step();
    wait_redirect(cyc);
    if (exp_q.size() == 0) begin n_vec++; n_err++; $display("FAIL stall_sb empty"); end
    else begin
      e = exp_q.pop_front();
      n_vec++; if (redirect_pc !== e.pc) begin n_err++; $display("FAIL stall_entry_pc got %h want %h", redirect_pc, e.pc); end
    end
    step();
    pc_next = 32'h80; irq_in = 4'b0011;
    exp_q.push_back('{pc: 32'h108, id: 2'd1, epc: 32'h80});
    eret = 1'b1; MIO_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (redirect !== 1'b0 || int_code !== 1'b1) begin n_err++; $display("FAIL stall_eret%0d got %b/%b want 0/1", k, redirect, int_code); end
      step();
    end
    MIO_ready = 1'b1; #1;
    n_vec++; if (redirect !== 1'b1 || redirect_pc !== 32'h40) begin n_err++; $display("FAIL stall_ret got %b/%h want 1/40", redirect, redirect_pc); end
    step();
    eret = 1'b0; MIO_ready = 1'b0; #1;
    n_vec++; if (redirect !== 1'b0 || int_code !== 1'b0) begin n_err++; $display("FAIL stall_guard got %b/%b want 0/0", redirect, int_code); end
    step();
    n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL stall_guard_hold got %b want 0", redirect); end
    MIO_ready = 1'b1; #1;
    n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL stall_guard_ready got %b want 0", redirect); end
    step();
    wait_redirect(cyc);
    n_vec++; if (cyc !== 0) begin n_err++; $display("FAIL stall_reentry_latency got %0d want 0", cyc); end
    if (exp_q.size() == 0) begin n_vec++; n_err++; $display("FAIL stall_sb2 empty"); end
    else begin
      e = exp_q.pop_front();
      n_vec++; if (redirect_pc !== e.pc) begin n_err++; $display("FAIL stall_reentry_pc got %h want %h", redirect_pc, e.pc); end
      step();
      n_vec++; if (int_id !== e.id || epc !== e.epc) begin n_err++; $display("FAIL stall_reentry_id got %0d/%h want %0d/%h", int_id, epc, e.id, e.epc); end
    end
    do_eret();
    irq_in = 4'b0000;
    step();
  endtask

  task automatic test_mask();
    cfg_write(2'd0, 32'h0);
    irq_in = 4'b0001; eret = 1'b1;
    step();
    step();
    eret = 1'b0;
    cfg_addr = 2'd1; #1;
    n_vec++; if (cfg_rdata !== 32'h1 || redirect !== 1'b0) begin n_err++; $display("FAIL mask_off got pend %h redirect %b want 1/0", cfg_rdata, redirect); end
    pc_next = 32'h300;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'h1; #1;
    n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL mask_write_cycle got %b want 0", redirect); end
    exp_q.push_back('{pc: 32'h100, id: 2'd0, epc: 32'h300});
    step();
    cfg_we = 1'b0;
    wait_redirect(cyc);
    n_vec++; if (cyc !== 0) begin n_err++; $display("FAIL mask_latency got %0d want 0", cyc); end
    if (exp_q.size() == 0) begin n_vec++; n_err++; $display("FAIL mask_sb empty"); end
    else begin
      e = exp_q.pop_front();
      n_vec++; if (redirect_pc !== e.pc) begin n_err++; $display("FAIL mask_pc got %h want %h", redirect_pc, e.pc); end
      step();
      n_vec++; if (epc !== e.epc) begin n_err++; $display("FAIL mask_epc got %h want %h", epc, e.epc); end
    end
    irq_in = 4'b0000;
    step();
    irq_in = 4'b0001;
    cfg_write(2'd1, 32'h1);
    cfg_addr = 2'd1; #1;
    n_vec++; if (cfg_rdata !== 32'h1) begin n_err++; $display("FAIL set_beats_w1c got %h want 1", cfg_rdata); end
    cfg_write(2'd1, 32'h1);
    cfg_addr = 2'd1; #1;
    n_vec++; if (cfg_rdata !== 32'h0) begin n_err++; $display("FAIL w1c_service got %h want 0", cfg_rdata); end
    do_eret();
    irq_in = 4'b0000;
    step();
  endtask

  task automatic test_async_reset();
    cfg_write(2'd0, 32'hF);
    pc_next = 32'h50; irq_in = 4'b0100;
    exp_q.push_back('{pc: 32'h110, id: 2'd2, epc: 32'h50});
    step();
    wait_redirect(cyc);
    if (exp_q.size() == 0) begin n_vec++; n_err++; $display("FAIL arst_sb empty"); end
    else begin
      e = exp_q.pop_front();
      n_vec++; if (redirect_pc !== e.pc) begin n_err++; $display("FAIL arst_entry_pc got %h want %h", redirect_pc, e.pc); end
    end
    step();
    n_vec++; if (int_code !== 1'b1) begin n_err++; $display("FAIL arst_pre got %b want 1", int_code); end
    eret = 1'b1;
    #1 rst = 1'b1;
    #1;
    n_vec++; if (int_code !== 1'b0 || redirect !== 1'b0 || redirect_pc !== 32'd0) begin n_err++; $display("FAIL arst_outs got %b/%b/%h want 0/0/0", int_code, redirect, redirect_pc); end
    cfg_addr = 2'd0; #1;
    n_vec++; if (cfg_rdata !== 32'h0) begin n_err++; $display("FAIL arst_mask got %h want 0", cfg_rdata); end
    cfg_addr = 2'd1; #1;
    n_vec++; if (cfg_rdata !== 32'h0) begin n_err++; $display("FAIL arst_pend got %h want 0", cfg_rdata); end
    cfg_addr = 2'd2; #1;
    n_vec++; if (cfg_rdata !== 32'h4) begin n_err++; $display("FAIL arst_base got %h want 4", cfg_rdata); end
    eret = 1'b0; irq_in = 4'b0000;
    @(posedge clk); #1 rst = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    cfg_write(2'd2, 32'h123);
    cfg_addr = 2'd2; #1;
    n_vec++; if (cfg_rdata !== 32'h120) begin n_err++; $display("FAIL base_low_bits got %h want 120", cfg_rdata); end
    cfg_write(2'd2, 32'hFFFF_FFF8);
    cfg_write(2'd0, 32'hF);
    pc_next = 32'h600; irq_in = 4'b1000;
    exp_q.push_back('{pc: 32'h10, id: 2'd3, epc: 32'h600});
    step();
    wait_redirect(cyc);
    if (exp_q.size() == 0) begin n_vec++; n_err++; $display("FAIL wrap_sb empty"); end
    else begin
      e = exp_q.pop_front();
      n_vec++; if (redirect_pc !== e.pc) begin n_err++; $display("FAIL wrap_pc got %h want %h", redirect_pc, e.pc); end
      step();
      n_vec++; if (int_id !== e.id) begin n_err++; $display("FAIL wrap_id got %0d want %0d", int_id, e.id); end
    end
    cfg_write(2'd3, 32'hDEAD_0000);
    cfg_addr = 2'd3; #1;
    n_vec++; if (cfg_rdata !== 32'h600) begin n_err++; $display("FAIL epc_ro got %h want 600", cfg_rdata); end
    do_eret();
    irq_in = 4'b0000;
    step();
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL sb_leftover got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; irq_in = 4'b0000; pc_next = 32'd0; MIO_ready = 1'b1; eret = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
    #12;
    test_reset();
    test_entry();
    test_priority();
    test_eret_stall();
    test_mask();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
